// File: rtl/spi_sram_pkg.sv
// Shared opcodes, mode encodings and responder states for the SPI SRAM responder.
package spi_sram_pkg;

    localparam int unsigned ADDR_BITS = 24;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDMR  = 8'h05;
    localparam logic [7:0] CMD_WRMR  = 8'h01;

    typedef enum logic [1:0] {
        MODE_BYTE = 2'b00,
        MODE_SEQ  = 2'b01,
        MODE_PAGE = 2'b10
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_MODE_RD,
        ST_MODE_WR,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for one SPI pin, with single-clk rise/fall pulses on the synced level.
module spi_pin_sync #(
    parameter int unsigned SYNC_FF   = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_FF-1:0] sync_q;
    logic               prev_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= {SYNC_FF{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_FF-2:0], d_i};
            prev_q <= sync_q[SYNC_FF-1];
        end
    end

    assign q_o    = sync_q[SYNC_FF-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder emulating a 23LC-style serial SRAM on a byte array;
// all logic runs on clk with the SPI pins oversampled.
module spi_sram_responder #(
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned PAGE    = 32,
    parameter int unsigned SYNC_FF = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       ce,
    input  logic       si,
    output logic       so,
    output logic       active,
    output logic       cmd_error,
    output logic [1:0] mode_reg
);
    import spi_sram_pkg::*;

    localparam int unsigned    AW    = $clog2(DEPTH);
    localparam logic [AW-1:0]  PMASK = AW'(PAGE - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic ce_s, ce_fall, ce_rise_unused;
    logic si_s, si_rise_unused, si_fall_unused;

    spi_pin_sync #(.SYNC_FF(SYNC_FF), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d_i(sclk),
        .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_pin_sync #(.SYNC_FF(SYNC_FF), .RESET_VAL(1'b1)) u_sync_ce (
        .clk(clk), .reset(reset), .d_i(ce),
        .q_o(ce_s), .rise_o(ce_rise_unused), .fall_o(ce_fall)
    );
    spi_pin_sync #(.SYNC_FF(SYNC_FF), .RESET_VAL(1'b0)) u_sync_si (
        .clk(clk), .reset(reset), .d_i(si),
        .q_o(si_s), .rise_o(si_rise_unused), .fall_o(si_fall_unused)
    );

    logic [7:0] mem [DEPTH];

    state_e        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [1:0]    abyte_q, abyte_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          is_wr_q, is_wr_d;
    logic [7:0]    osh_q, osh_d;
    logic [2:0]    obit_q, obit_d;
    logic          sent_q, sent_d;
    logic          so_q, so_d;
    logic [1:0]    mode_q, mode_d;
    logic          err_q, err_d;

    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    rx_byte;
    logic [7:0]    load_val;
    logic          byte_done;
    logic          unused_sclk;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [1:0] m);
        if (m == MODE_PAGE)
            return (a & ~PMASK) | ((a + AW'(1)) & PMASK);
        return a + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            abyte_q  <= '0;
            addr_q   <= '0;
            is_wr_q  <= 1'b0;
            osh_q    <= '0;
            obit_q   <= '0;
            sent_q   <= 1'b0;
            so_q     <= 1'b0;
            mode_q   <= MODE_SEQ;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            abyte_q  <= abyte_d;
            addr_q   <= addr_d;
            is_wr_q  <= is_wr_d;
            osh_q    <= osh_d;
            obit_q   <= obit_d;
            sent_q   <= sent_d;
            so_q     <= so_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && mem_we)
            mem[addr_q] <= mem_wdata;
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        abyte_d   = abyte_q;
        addr_d    = addr_q;
        is_wr_d   = is_wr_q;
        osh_d     = osh_q;
        obit_d    = obit_q;
        sent_d    = sent_q;
        so_d      = so_q;
        mode_d    = mode_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        rx_byte   = {shreg_q[6:0], si_s};
        byte_done = sclk_rise && (bitcnt_q == 3'd7);
        load_val  = (state_q == ST_MODE_RD) ? {mode_q, 6'b0} : mem[addr_q];

        // Synced ce high overrides everything, including a coincident sclk rise.
        if (ce_s) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
            abyte_d  = '0;
            obit_d   = '0;
            sent_d   = 1'b0;
            so_d     = 1'b0;
        end else begin
            if (sclk_rise) begin
                shreg_d  = rx_byte;
                bitcnt_d = bitcnt_q + 3'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (ce_fall) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            CMD_READ:  begin state_d = ST_ADDR; is_wr_d = 1'b0; end
                            CMD_WRITE: begin state_d = ST_ADDR; is_wr_d = 1'b1; end
                            CMD_RDMR:  state_d = ST_MODE_RD;
                            CMD_WRMR:  state_d = ST_MODE_WR;
                            default: begin
                                state_d = ST_IGNORE;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    // Shifting through an AW-bit register keeps only the low address bits.
                    if (sclk_rise) addr_d = AW'({addr_q, si_s});
                    if (byte_done) begin
                        abyte_d = abyte_q + 2'd1;
                        if (abyte_q == 2'd2) begin
                            abyte_d = '0;
                            state_d = is_wr_q ? ST_WR_DATA : ST_RD_DATA;
                        end
                    end
                end
                ST_RD_DATA, ST_MODE_RD: begin
                    if (sclk_fall) begin
                        if (obit_q == 3'd0) begin
                            if (state_q == ST_RD_DATA && sent_q && mode_q == MODE_BYTE) begin
                                state_d = ST_IGNORE;
                                so_d    = 1'b0;
                            end else begin
                                so_d   = load_val[7];
                                osh_d  = {load_val[6:0], 1'b0};
                                obit_d = 3'd1;
                                sent_d = 1'b1;
                            end
                        end else begin
                            so_d   = osh_q[7];
                            osh_d  = {osh_q[6:0], 1'b0};
                            obit_d = obit_q + 3'd1;
                            // Advance while the last bit is on the wire so the next fall loads the new byte.
                            if (obit_q == 3'd7 && state_q == ST_RD_DATA)
                                addr_d = next_addr(addr_q, mode_q);
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (byte_done) begin
                        mem_we    = 1'b1;
                        mem_wdata = rx_byte;
                        addr_d    = next_addr(addr_q, mode_q);
                        if (mode_q == MODE_BYTE) state_d = ST_IGNORE;
                    end
                end
                ST_MODE_WR: begin
                    if (byte_done) begin
                        mode_d  = (rx_byte[7:6] == 2'b11) ? MODE_SEQ : rx_byte[7:6];
                        state_d = ST_IGNORE;
                    end
                end
                ST_IGNORE: begin
                    so_d = 1'b0;
                end
            endcase
        end
    end

    assign unused_sclk = sclk_s;
    assign so          = so_q;
    assign active      = ~ce_s;
    assign cmd_error   = err_q;
    assign mode_reg    = mode_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: frame-level byte-array reference model plus literal checks.
module tb_spi_sram_responder;

    localparam int DEPTH = 4096;
    localparam int PAGE  = 32;

    logic       clk = 1'b0;
    logic       reset, sclk, ce, si;
    logic       so, active, cmd_error;
    logic [1:0] mode_reg;

    spi_sram_responder #(.DEPTH(DEPTH), .PAGE(PAGE), .SYNC_FF(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .ce(ce), .si(si),
        .so(so), .active(active), .cmd_error(cmd_error), .mode_reg(mode_reg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] txb [16];
    logic [7:0] rxb [16];
    logic [7:0] exp_rx [16];
    bit         exp_ok [16];

    logic [7:0] m_mem [DEPTH];
    bit         m_valid [DEPTH];
    logic [1:0] m_mode = 2'b01;
    int         m_err = 0;
    int         dut_err = 0;
    bit         chk_idle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) if (cmd_error === 1'b1) dut_err++;

    // Between frames the responder must be quiet and report the modelled mode.
    always @(negedge clk) begin
        if (chk_idle) begin
            check("idle_so", {31'b0, so}, 32'd0);
            check("idle_active", {31'b0, active}, 32'd0);
            check("idle_cmd_error", {31'b0, cmd_error}, 32'd0);
            check("idle_mode_reg", {30'b0, mode_reg}, {30'b0, m_mode});
        end
    end

    function automatic int adv(input int a, input logic [1:0] m);
        if (m == 2'b10) return (a / PAGE) * PAGE + ((a % PAGE) + 1) % PAGE;
        return (a + 1) % DEPTH;
    endfunction

    // Frame-level model: n complete bytes in txb; fills exp_rx and updates memory/mode/errors.
    task automatic model_frame(input int n);
        int a;
        for (int i = 0; i < 16; i++) begin
            exp_rx[i] = 8'h00;
            exp_ok[i] = 1'b1;
        end
        if (n == 0) return;
        a = int'({txb[1], txb[2], txb[3]}) % DEPTH;
        case (txb[0])
            8'h03: for (int i = 4; i < n; i++) begin
                if (m_mode == 2'b00 && i > 4) exp_rx[i] = 8'h00;
                else begin
                    exp_rx[i] = m_mem[a];
                    exp_ok[i] = m_valid[a];
                    a = adv(a, m_mode);
                end
            end
            8'h02: for (int i = 4; i < n; i++) begin
                if (!(m_mode == 2'b00 && i > 4)) begin
                    m_mem[a]   = txb[i];
                    m_valid[a] = 1'b1;
                    a = adv(a, m_mode);
                end
            end
            8'h05: for (int i = 1; i < n; i++) exp_rx[i] = {m_mode, 6'b0};
            8'h01: if (n >= 2) m_mode = (txb[1][7:6] == 2'b11) ? 2'b01 : txb[1][7:6];
            default: m_err++;
        endcase
    endtask

    task automatic bit_out(input logic b, output logic r);
        si = b;
        repeat (4) @(negedge clk);
        r = so;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic xfer(input int n, input int pbits);
        logic r;
        ce = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < n + ((pbits > 0) ? 1 : 0); i++) begin
            int nb;
            nb = (i < n) ? 8 : pbits;
            rxb[i] = 8'h00;
            for (int b = 7; b >= 8 - nb; b--) begin
                bit_out(txb[i][b], r);
                rxb[i][b] = r;
                if (i < n && exp_ok[i]) check("so_bit", {31'b0, r}, {31'b0, exp_rx[i][b]});
            end
        end
        repeat (4) @(negedge clk);
        ce = 1'b1;
        si = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic run(input int n, input int pbits);
        chk_idle = 1'b0;
        model_frame(n);
        xfer(n, pbits);
        check("cmd_error_pulses", dut_err, m_err);
        chk_idle = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic hdr(input logic [7:0] op, input logic [23:0] addr);
        txb[0] = op;
        txb[1] = addr[23:16];
        txb[2] = addr[15:8];
        txb[3] = addr[7:0];
        for (int i = 4; i < 16; i++) txb[i] = 8'h00;
    endtask

    task automatic wr(input logic [23:0] addr, input logic [31:0] data, input int n);
        hdr(8'h02, addr);
        for (int i = 0; i < n; i++) txb[4 + i] = data[31 - 8 * i -: 8];
        run(4 + n, 0);
    endtask

    task automatic rd(input logic [23:0] addr, input int n);
        hdr(8'h03, addr);
        run(4 + n, 0);
    endtask

    task automatic wrmr(input logic [7:0] v);
        txb[0] = 8'h01;
        txb[1] = v;
        run(2, 0);
    endtask

    task automatic rdmr();
        txb[0] = 8'h05;
        txb[1] = 8'h00;
        run(2, 0);
    endtask

    initial begin
        logic r;
        reset = 1'b0; sclk = 1'b0; ce = 1'b1; si = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_so", {31'b0, so}, 32'd0);
        check("rst_active", {31'b0, active}, 32'd0);
        check("rst_cmd_error", {31'b0, cmd_error}, 32'd0);
        check("rst_mode_reg", {30'b0, mode_reg}, 32'd1);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk_idle = 1'b1;

        // Sequential write/read
        wr(24'h000010, 32'hDEADBEEF, 4);
        rd(24'h000010, 4);
        check("seq_rd0", rxb[4], 8'hDE);
        check("seq_rd1", rxb[5], 8'hAD);
        check("seq_rd2", rxb[6], 8'hBE);
        check("seq_rd3", rxb[7], 8'hEF);

        // Wrap at end of array
        wr(24'h000FFE, 32'h11223300, 3);
        rd(24'h000FFE, 3);
        check("wrap_rd0", rxb[4], 8'h11);
        check("wrap_rd1", rxb[5], 8'h22);
        check("wrap_rd2", rxb[6], 8'h33);

        // Page mode
        wr(24'h000020, 32'h77000000, 1);
        wrmr(8'h80);
        rdmr();
        check("rdmr_page", rxb[1], 8'h80);
        wr(24'h00001F, 32'hAABB0000, 2);
        rd(24'h00001F, 2);
        check("page_rd0", rxb[4], 8'hAA);
        check("page_rd1", rxb[5], 8'hBB);
        rd(24'h000000, 1);
        check("page_wrap_lands_0", rxb[4], 8'hBB);
        rd(24'h000020, 1);
        check("page_0x20_kept", rxb[4], 8'h77);
        wr(24'h000006, 32'hA5000000, 1);

        // Byte mode
        wrmr(8'h00);
        rdmr();
        check("rdmr_byte", rxb[1], 8'h00);
        wr(24'h000005, 32'h55660000, 2);
        rd(24'h000005, 2);
        check("byte_rd0", rxb[4], 8'h55);
        check("byte_rd_extra", rxb[5], 8'h00);
        rd(24'h000006, 1);
        check("byte_mem6_kept", rxb[4], 8'hA5);

        // Unknown opcode
        txb[0] = 8'h9F; txb[1] = 8'hFF; txb[2] = 8'hFF;
        run(3, 0);
        check("bad_op_so", {rxb[1], rxb[2]}, 16'h0000);
        check("bad_op_pulses", dut_err, 1);
        rd(24'h000010, 1);
        check("after_bad_op_rd", rxb[4], 8'hDE);

        // Mode 11 stored as sequential
        wrmr(8'hC0);
        rdmr();
        check("rdmr_11_as_seq", rxb[1], 8'h40);

        // Abort mid-byte on write
        hdr(8'h02, 24'h000011);
        txb[4] = 8'hFF;
        run(4, 4);
        rd(24'h000011, 1);
        check("abort_no_write", rxb[4], 8'hAD);

        // Reset mid-read
        wrmr(8'h80);
        chk_idle = 1'b0;
        hdr(8'h03, 24'h000010);
        ce = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++)
            for (int b = 7; b >= 0; b--) bit_out(txb[i][b], r);
        repeat (4) @(negedge clk);
        check("pre_reset_so", {31'b0, so}, 32'd1);
        check("pre_reset_active", {31'b0, active}, 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_so", {31'b0, so}, 32'd0);
        check("midrst_active", {31'b0, active}, 32'd0);
        check("midrst_mode_reg", {30'b0, mode_reg}, 32'd1);
        m_mode = 2'b01;
        ce = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk_idle = 1'b1;
        repeat (8) @(negedge clk);
        chk_idle = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
